long_inst_tracker: RTL and testbench

Scoreboard for long-latency instructions (MUL/DIV and loads/stores through the AGU/LSU). It hands a commit ID to each long instruction at dispatch and records its destination register. From that record it raises RAW/WAW stalls for younger instructions. It frees the entry when the writeback stage reports `commit_valid`/`commit_id`, so it sits directly downstream of the writeback unit's commit outputs and feeds the decode/dispatch stall logic.

---
 rtl/long_inst_tracker_pkg.sv | 16 +
 rtl/long_inst_tracker_lit_find_free.sv | 20 ++
 rtl/long_inst_tracker.sv | 148 ++++++++++++++
 tb/tb_long_inst_tracker.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/long_inst_tracker_pkg.sv
// Shared types and helpers for the long-latency instruction tracker.
// The tracker's optional commit checker is enabled with LIT_COMMIT_CHECK_EN.
package long_inst_tracker_pkg;

  localparam int LIT_REG_ADDR_W = 5;

  typedef struct packed {
    logic                      valid;
    logic [LIT_REG_ADDR_W-1:0] rd;
  } lit_entry_t;

  function automatic int LIT_CNT_W(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/long_inst_tracker_lit_find_free.sv
// Lowest-zero priority encoder over the entry valid vector.
module lit_find_free #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [ENTRIES-1:0] valid_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               none_o
);

  always_comb begin
    idx_o  = '0;
    none_o = &valid_i;
    // Scan downward so the lowest free index is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/long_inst_tracker.sv
// Scoreboard for long-latency instructions: grants commit IDs, raises RAW/WAW stalls.
// Define LIT_COMMIT_CHECK_EN to build the sticky protocol-error checker on err_o.
module long_inst_tracker
  import long_inst_tracker_pkg::*;
#(
  parameter int ENTRIES         = 4,
  parameter int COMMIT_ID_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_valid_i,
  input  logic [LIT_REG_ADDR_W-1:0]       alloc_rd_i,
  output logic [COMMIT_ID_WIDTH-1:0]      alloc_id_o,
  output logic                            alloc_ready_o,
  input  logic                            rs1_re_i,
  input  logic                            rs2_re_i,
  input  logic [LIT_REG_ADDR_W-1:0]       rs1_addr_i,
  input  logic [LIT_REG_ADDR_W-1:0]       rs2_addr_i,
  input  logic                            rd_we_i,
  input  logic [LIT_REG_ADDR_W-1:0]       rd_addr_i,
  output logic                            stall_o,
  output logic                            raw_hazard_o,
  output logic                            waw_hazard_o,
  input  logic                            commit_valid_i,
  input  logic [COMMIT_ID_WIDTH-1:0]      commit_id_i,
  input  logic                            flush_i,
  output logic                            busy_o,
  output logic [LIT_CNT_W(ENTRIES)-1:0]   count_o,
  output logic                            err_o
);

  localparam int CNT_W = LIT_CNT_W(ENTRIES);

  logic [ENTRIES-1:0]        r_valid;
  logic [LIT_REG_ADDR_W-1:0] r_rd [ENTRIES];
  logic [CNT_W-1:0]          r_count;
  logic                      r_busy;

  lit_entry_t                w_entry [ENTRIES];
  logic [ENTRIES-1:0]        w_hit;
  logic [ENTRIES-1:0]        w_live;
  logic [COMMIT_ID_WIDTH-1:0] w_free_idx;
  logic                      w_none;
  logic                      w_raw;
  logic                      w_waw;
  logic                      w_stall;
  logic                      w_accept;
  logic                      w_commit_dec;
  logic [CNT_W-1:0]          w_count_nxt;

  lit_find_free #(
    .ENTRIES (ENTRIES),
    .IDX_W   (COMMIT_ID_WIDTH)
  ) u_find_free (
    .valid_i (r_valid),
    .idx_o   (w_free_idx),
    .none_o  (w_none)
  );

  // An entry being committed this cycle no longer blocks: the regfile writes through.
  always_comb begin
    w_hit        = '0;
    w_live       = '0;
    w_raw        = 1'b0;
    w_waw        = 1'b0;
    w_commit_dec = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_entry[i].valid = r_valid[i];
      w_entry[i].rd    = r_rd[i];
      w_hit[i]  = commit_valid_i && (commit_id_i == COMMIT_ID_WIDTH'(i));
      w_live[i] = w_entry[i].valid && !w_hit[i] && (w_entry[i].rd != '0);
      if (w_live[i] && ((rs1_re_i && (rs1_addr_i == w_entry[i].rd)) ||
                        (rs2_re_i && (rs2_addr_i == w_entry[i].rd))))
        w_raw = 1'b1;
      if (w_live[i] && rd_we_i && (rd_addr_i == w_entry[i].rd))
        w_waw = 1'b1;
      if (w_hit[i] && w_entry[i].valid)
        w_commit_dec = 1'b1;
    end
  end

  assign alloc_ready_o = !w_none;
  assign alloc_id_o    = w_none ? '0 : w_free_idx;
  assign raw_hazard_o  = w_raw;
  assign waw_hazard_o  = w_waw;
  assign w_stall       = w_raw || w_waw || (alloc_valid_i && w_none);
  assign stall_o       = w_stall;
  assign w_accept      = alloc_valid_i && !w_stall && !flush_i;

  always_comb begin
    w_count_nxt = r_count;
    if (flush_i)
      w_count_nxt = '0;
    else
      w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_commit_dec);
  end

  // Accept targets a free entry, so it overrides a commit aimed at that same free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_hit[i]) r_valid[i] <= 1'b0;
        if (w_accept && (alloc_id_o == COMMIT_ID_WIDTH'(i))) r_valid[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_accept && (alloc_id_o == COMMIT_ID_WIDTH'(i))) r_rd[i] <= alloc_rd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);
    end
  end

  assign count_o = r_count;
  assign busy_o  = r_busy;

`ifdef LIT_COMMIT_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((commit_valid_i && !w_commit_dec) ||
                 (alloc_valid_i && w_none && !w_raw && !w_waw)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_long_inst_tracker.sv
// Randomised and directed bench for long_inst_tracker against a behavioural scoreboard.
module tb_long_inst_tracker;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid_i;
  logic [4:0] alloc_rd_i;
  logic [1:0] alloc_id_o;
  logic       alloc_ready_o;
  logic       rs1_re_i, rs2_re_i;
  logic [4:0] rs1_addr_i, rs2_addr_i;
  logic       rd_we_i;
  logic [4:0] rd_addr_i;
  logic       stall_o, raw_hazard_o, waw_hazard_o;
  logic       commit_valid_i;
  logic [1:0] commit_id_i;
  logic       flush_i;
  logic       busy_o;
  logic [2:0] count_o;
  logic       err_o;

  int n_checks = 0;
  int n_fail   = 0;

  bit       mv  [N];
  bit [4:0] mrd [N];
  bit       m_err;

  long_inst_tracker #(.ENTRIES(4), .COMMIT_ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid_i), .alloc_rd_i(alloc_rd_i),
    .alloc_id_o(alloc_id_o), .alloc_ready_o(alloc_ready_o),
    .rs1_re_i(rs1_re_i), .rs2_re_i(rs2_re_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
    .stall_o(stall_o), .raw_hazard_o(raw_hazard_o), .waw_hazard_o(waw_hazard_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .flush_i(flush_i), .busy_o(busy_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_blocks(int i);
    return mv[i] && (mrd[i] != 0) && !(commit_valid_i && (int'(commit_id_i) == i));
  endfunction

  function automatic bit m_raw();
    for (int i = 0; i < N; i++)
      if (m_blocks(i) && ((rs1_re_i && rs1_addr_i == mrd[i]) || (rs2_re_i && rs2_addr_i == mrd[i])))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_waw();
    for (int i = 0; i < N; i++)
      if (m_blocks(i) && rd_we_i && rd_addr_i == mrd[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    for (int i = 0; i < N; i++) if (!mv[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_id();
    for (int i = 0; i < N; i++) if (!mv[i]) return i;
    return 0;
  endfunction

  function automatic bit m_stall();
    return m_raw() || m_waw() || (alloc_valid_i && !m_ready());
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (mv[i]) c++;
    return c;
  endfunction

  task automatic idle_inputs();
    alloc_valid_i = 0; alloc_rd_i = 0;
    rs1_re_i = 0; rs2_re_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    rd_we_i = 0; rd_addr_i = 0;
    commit_valid_i = 0; commit_id_i = 0; flush_i = 0;
  endtask

  // Advance one clock edge, updating the scoreboard from the inputs presented.
  task automatic tick();
    bit acc, e;
    int id;
    id  = m_id();
    acc = alloc_valid_i && !m_stall() && !flush_i;
    e   = (commit_valid_i && !mv[commit_id_i]) ||
          (alloc_valid_i && !m_ready() && !m_raw() && !m_waw());
    @(posedge clk);
    if (flush_i) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
    end else begin
      if (commit_valid_i) mv[commit_id_i] = 0;
      if (acc) begin mv[id] = 1; mrd[id] = alloc_rd_i; end
    end
`ifdef LIT_COMMIT_CHECK_EN
    if (e) m_err = 1;
`else
    if (e) m_err = 0;
`endif
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mrd[i] = 0; end
    m_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({alloc_ready_o, alloc_id_o, stall_o, busy_o, raw_hazard_o, waw_hazard_o, count_o, err_o}
        !== {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b id=%0d stall=%b busy=%b raw=%b waw=%b cnt=%0d err=%b, want 1 0 0 0 0 0 0 0",
               alloc_ready_o, alloc_id_o, stall_o, busy_o, raw_hazard_o, waw_hazard_o, count_o, err_o);
    end
  endtask

  task automatic test_alloc_raw();
    apply_reset();
    alloc_valid_i = 1; alloc_rd_i = 5; #1;
    n_checks++;
    if (alloc_id_o !== 2'd0) begin n_fail++; $display("FAIL alloc_id_first: got %0d want 0", alloc_id_o); end
    tick(); #1;
    n_checks++;
    if (count_o !== 3'd1 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL alloc_count: got cnt=%0d busy=%b want 1 1", count_o, busy_o);
    end
    rs1_re_i = 1; rs1_addr_i = 5; #1;
    n_checks++;
    if (raw_hazard_o !== 1'b1 || stall_o !== 1'b1) begin
      n_fail++; $display("FAIL raw_rs1: got raw=%b stall=%b want 1 1", raw_hazard_o, stall_o);
    end
  endtask

  task automatic test_commit_bypass();
    apply_reset();
    alloc_valid_i = 1; alloc_rd_i = 5; tick();
    rs2_re_i = 1; rs2_addr_i = 5; commit_valid_i = 1; commit_id_i = 0; #1;
    n_checks++;
    if (raw_hazard_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL commit_bypass: got raw=%b stall=%b want 0 0", raw_hazard_o, stall_o);
    end
    tick(); #1;
    n_checks++;
    if (count_o !== 3'd0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL commit_count: got cnt=%0d busy=%b want 0 0", count_o, busy_o);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      alloc_valid_i = 1; alloc_rd_i = 5'(k); #1;
      n_checks++;
      if (alloc_id_o !== 2'(k - 1)) begin
        n_fail++; $display("FAIL fill_id%0d: got %0d want %0d", k, alloc_id_o, k - 1);
      end
      tick();
    end
    alloc_valid_i = 1; alloc_rd_i = 7; #1;
    n_checks++;
    if (alloc_ready_o !== 1'b0 || stall_o !== 1'b1 || alloc_id_o !== 2'd0) begin
      n_fail++; $display("FAIL full_stall: got rdy=%b stall=%b id=%0d want 0 1 0", alloc_ready_o, stall_o, alloc_id_o);
    end
    tick(); #1;
    n_checks++;
    if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_no_accept: got cnt=%0d want 4", count_o); end
    commit_valid_i = 1; commit_id_i = 2; #1;
    n_checks++;
    if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_commit_same: got rdy=%b want 0", alloc_ready_o); end
    tick(); #1;
    n_checks++;
    if (alloc_ready_o !== 1'b1 || alloc_id_o !== 2'd2 || count_o !== 3'd3) begin
      n_fail++; $display("FAIL freed_id: got rdy=%b id=%0d cnt=%0d want 1 2 3", alloc_ready_o, alloc_id_o, count_o);
    end
  endtask

  task automatic test_store_waw();
    apply_reset();
    alloc_valid_i = 1; alloc_rd_i = 0; tick(); #1;
    n_checks++;
    if (count_o !== 3'd1 || alloc_id_o !== 2'd1) begin
      n_fail++; $display("FAIL store_alloc: got cnt=%0d id=%0d want 1 1", count_o, alloc_id_o);
    end
    rs1_re_i = 1; rs1_addr_i = 0; rd_we_i = 1; rd_addr_i = 0; #1;
    n_checks++;
    if (raw_hazard_o !== 1'b0 || waw_hazard_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_no_hazard: got raw=%b waw=%b stall=%b want 0 0 0", raw_hazard_o, waw_hazard_o, stall_o);
    end
    idle_inputs(); alloc_valid_i = 1; alloc_rd_i = 3; tick();
    rd_we_i = 1; rd_addr_i = 3; #1;
    n_checks++;
    if (waw_hazard_o !== 1'b1 || raw_hazard_o !== 1'b0 || stall_o !== 1'b1) begin
      n_fail++; $display("FAIL waw_hit: got waw=%b raw=%b stall=%b want 1 0 1", waw_hazard_o, raw_hazard_o, stall_o);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int k = 0; k < 3; k++) begin alloc_valid_i = 1; alloc_rd_i = 5'(10 + k); tick(); end
    alloc_valid_i = 1; alloc_rd_i = 20; flush_i = 1; tick(); #1;
    n_checks++;
    if (count_o !== 3'd0 || busy_o !== 1'b0 || alloc_id_o !== 2'd0 || alloc_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear: got cnt=%0d busy=%b id=%0d rdy=%b want 0 0 0 1",
                         count_o, busy_o, alloc_id_o, alloc_ready_o);
    end
    for (int k = 0; k < 3; k++) begin
      rs1_re_i = 1; rs1_addr_i = 5'(10 + k); rd_we_i = 1; rd_addr_i = 20; #1;
      n_checks++;
      if (raw_hazard_o !== 1'b0 || waw_hazard_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_entry%0d: got raw=%b waw=%b want 0 0", k, raw_hazard_o, waw_hazard_o);
      end
    end
    idle_inputs();
  endtask

  task automatic test_err();
    bit want;
`ifdef LIT_COMMIT_CHECK_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    apply_reset();
    commit_valid_i = 1; commit_id_i = 1; tick(); #1;
    n_checks++;
    if (err_o !== want || err_o !== m_err) begin
      n_fail++; $display("FAIL err_set: got %b want %b", err_o, want);
    end
    tick(); tick(); tick(); #1;
    n_checks++;
    if (err_o !== want) begin n_fail++; $display("FAIL err_sticky: got %b want %b", err_o, want); end
    alloc_valid_i = 1; alloc_rd_i = 9; tick();
    rst_n = 0; #1;
    n_checks++;
    if (err_o !== 1'b0 || count_o !== 3'd0 || alloc_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got err=%b cnt=%0d rdy=%b want 0 0 1", err_o, count_o, alloc_ready_o);
    end
    for (int i = 0; i < N; i++) mv[i] = 0;
    m_err = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      alloc_valid_i  = ($urandom_range(0, 99) < 55);
      alloc_rd_i     = 5'($urandom_range(0, 7));
      rs1_re_i       = $urandom_range(0, 1);
      rs2_re_i       = $urandom_range(0, 1);
      rs1_addr_i     = 5'($urandom_range(0, 7));
      rs2_addr_i     = 5'($urandom_range(0, 7));
      rd_we_i        = $urandom_range(0, 1);
      rd_addr_i      = 5'($urandom_range(0, 7));
      commit_valid_i = ($urandom_range(0, 99) < 35);
      commit_id_i    = 2'($urandom_range(0, 3));
      flush_i        = ($urandom_range(0, 99) < 3);
      #1;
      n_checks++;
      if ({alloc_ready_o, alloc_id_o, stall_o, raw_hazard_o, waw_hazard_o, busy_o, count_o, err_o} !==
          {m_ready(), 2'(m_id()), m_stall(), m_raw(), m_waw(), (m_count() != 0), 3'(m_count()), m_err}) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_c%0d: got rdy=%b id=%0d st=%b raw=%b waw=%b busy=%b cnt=%0d err=%b want %b %0d %b %b %b %b %0d %b",
                   c, alloc_ready_o, alloc_id_o, stall_o, raw_hazard_o, waw_hazard_o, busy_o, count_o, err_o,
                   m_ready(), m_id(), m_stall(), m_raw(), m_waw(), (m_count() != 0), m_count(), m_err);
        errs++;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    test_reset();
    test_alloc_raw();
    test_commit_bypass();
    test_full();
    test_store_waw();
    test_flush();
    test_err();
    apply_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
